// File: rtl/int8_mac_seq.sv
// Sequencer for one int8_mac engine: fetches A/B chunk pairs, drives the MAC chunk by chunk,
// carries the running sum through the MAC partial-sum input and returns the final sum.
module int8_mac_seq #(
    parameter int VEC_W  = 264,
    parameter int ACC_W  = 24,
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [CNT_W-1:0]  cmd_chunks,
    input  logic [ADDR_W-1:0] cmd_base,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_valid,
    input  logic [VEC_W-1:0]  rd_a,
    input  logic [VEC_W-1:0]  rd_b,
    output logic              mac_en,
    output logic [VEC_W-1:0]  mac_a,
    output logic [VEC_W-1:0]  mac_b,
    output logic [ACC_W-1:0]  mac_psum_in,
    input  logic [ACC_W-1:0]  mac_psum_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              busy
);

    typedef enum logic [2:0] {IDLE, FETCH, MAC, CAPTURE, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  idx;
    logic [ACC_W-1:0]  acc;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign rd_addr   = addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            count       <= '0;
            idx         <= '0;
            acc         <= '0;
            rd_req      <= 1'b0;
            mac_en      <= 1'b0;
            mac_a       <= '0;
            mac_b       <= '0;
            mac_psum_in <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        count <= cmd_chunks;
                        addr  <= cmd_base;
                        idx   <= '0;
                        acc   <= '0;
                        if (cmd_chunks == '0) begin
                            res_data  <= '0;
                            res_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            rd_req <= 1'b1;
                            state  <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (rd_valid) begin
                        mac_a       <= rd_a;
                        mac_b       <= rd_b;
                        rd_req      <= 1'b0;
                        mac_en      <= 1'b1;
                        mac_psum_in <= acc;
                        state       <= MAC;
                    end
                end
                MAC: begin
                    mac_en <= 1'b0;
                    state  <= CAPTURE;
                end
                CAPTURE: begin
                    // The MAC output is registered, so the chunk's sum is only visible here.
                    acc  <= mac_psum_out;
                    addr <= addr + ADDR_W'(1);
                    idx  <= idx + CNT_W'(1);
                    if (idx == count - CNT_W'(1)) begin
                        res_data  <= mac_psum_out;
                        res_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        rd_req <= 1'b1;
                        state  <= FETCH;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_int8_mac_seq.sv
// Bench for int8_mac_seq: emulated operand buffer and MAC, reference sums from plain arithmetic.
module tb_int8_mac_seq;

    localparam int VEC_W  = 264;
    localparam int ACC_W  = 24;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 8;
    localparam int LANES  = VEC_W / 8;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [CNT_W-1:0]  cmd_chunks;
    logic [ADDR_W-1:0] cmd_base;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_valid;
    logic [VEC_W-1:0]  rd_a;
    logic [VEC_W-1:0]  rd_b;
    logic              mac_en;
    logic [VEC_W-1:0]  mac_a;
    logic [VEC_W-1:0]  mac_b;
    logic [ACC_W-1:0]  mac_psum_in;
    logic [ACC_W-1:0]  mac_psum_out;
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic              busy;

    logic [VEC_W-1:0]  mem_a [DEPTH];
    logic [VEC_W-1:0]  mem_b [DEPTH];
    logic              stall;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    int8_mac_seq #(
        .VEC_W (VEC_W),
        .ACC_W (ACC_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_chunks  (cmd_chunks),
        .cmd_base    (cmd_base),
        .rd_req      (rd_req),
        .rd_addr     (rd_addr),
        .rd_valid    (rd_valid),
        .rd_a        (rd_a),
        .rd_b        (rd_b),
        .mac_en      (mac_en),
        .mac_a       (mac_a),
        .mac_b       (mac_b),
        .mac_psum_in (mac_psum_in),
        .mac_psum_out(mac_psum_out),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .busy        (busy)
    );

    // Zero-wait operand buffer unless the stimulus asks for a stall.
    assign rd_valid = rd_req & ~stall;
    assign rd_a     = mem_a[rd_addr];
    assign rd_b     = mem_b[rd_addr];

    function automatic logic [ACC_W-1:0] lane_dot(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
        int s;
        s = 0;
        for (int i = 0; i < LANES; i++)
            s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
        return s[ACC_W-1:0];
    endfunction

    // Emulated MAC: one registered stage, output cleared when disabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)         mac_psum_out <= '0;
        else if (mac_en) mac_psum_out <= mac_psum_in + lane_dot(mac_a, mac_b);
        else             mac_psum_out <= '0;
    end

    function automatic logic [ACC_W-1:0] ref_result(input logic [ADDR_W-1:0] base, input int n);
        longint total;
        int     ad;
        total = 0;
        for (int c = 0; c < n; c++) begin
            ad = (int'(base) + c) % DEPTH;
            for (int i = 0; i < LANES; i++)
                total += longint'($signed(mem_a[ad][8*i +: 8])) * longint'($signed(mem_b[ad][8*i +: 8]));
        end
        return total[ACC_W-1:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill_const(input logic [ADDR_W-1:0] base, input int n, input logic [7:0] av, input logic [7:0] bv);
        for (int c = 0; c < n; c++) begin
            mem_a[(int'(base) + c) % DEPTH] = {LANES{av}};
            mem_b[(int'(base) + c) % DEPTH] = {LANES{bv}};
        end
    endtask

    task automatic fill_rand(input logic [ADDR_W-1:0] base, input int n);
        int ad;
        for (int c = 0; c < n; c++) begin
            ad = (int'(base) + c) % DEPTH;
            for (int i = 0; i < LANES; i++) begin
                mem_a[ad][8*i +: 8] = 8'($urandom);
                mem_b[ad][8*i +: 8] = 8'($urandom);
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"},   32'(cmd_ready), 32'd1);
        check({tag, "_rd_req"},      32'(rd_req), 32'd0);
        check({tag, "_rd_addr"},     32'(rd_addr), 32'd0);
        check({tag, "_mac_en"},      32'(mac_en), 32'd0);
        check({tag, "_mac_a_zero"},  32'(mac_a === '0), 32'd1);
        check({tag, "_mac_b_zero"},  32'(mac_b === '0), 32'd1);
        check({tag, "_mac_psum_in"}, 32'(mac_psum_in), 32'd0);
        check({tag, "_res_valid"},   32'(res_valid), 32'd0);
        check({tag, "_res_data"},    32'(res_data), 32'd0);
        check({tag, "_busy"},        32'(busy), 32'd0);
    endtask

    // Issues one command and follows it to the result; called at posedge+1 with the DUT idle.
    task automatic run_cmd(input string tag, input logic [ADDR_W-1:0] base, input int n,
                           input int stall_chunk, input int stall_n, input int hold, input bit keep_valid);
        logic [ACC_W-1:0]  exp;
        logic [ADDR_W-1:0] ea;
        int cyc, fetch_i, left, extra;
        bit saw_rd, saw_mac, done;
        exp     = ref_result(base, n);
        extra   = (stall_chunk >= 0 && stall_chunk < n) ? stall_n : 0;
        fetch_i = 0;
        left    = stall_n;
        saw_rd  = 1'b0;
        saw_mac = 1'b0;
        done    = 1'b0;
        res_ready  = 1'b0;
        cmd_valid  = 1'b1;
        cmd_chunks = CNT_W'(n);
        cmd_base   = base;
        check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        if (!keep_valid) cmd_valid = 1'b0;
        cyc = 1;
        while (!done && cyc < 3000) begin
            stall = rd_req && (fetch_i == stall_chunk) && (left > 0);
            if (stall) left--;
            #1;
            if (rd_req) saw_rd = 1'b1;
            if (mac_en) saw_mac = 1'b1;
            if (res_valid) begin
                done = 1'b1;
            end else begin
                if (rd_req) begin
                    ea = base + ADDR_W'(fetch_i);
                    check($sformatf("%s_rd_addr%0d%s", tag, fetch_i, stall ? "_stall" : ""), 32'(rd_addr), 32'(ea));
                    if (rd_valid) fetch_i++;
                end
                @(posedge clk); #1;
                cyc++;
            end
        end
        stall = 1'b0;
        check({tag, "_res_valid_seen"}, 32'(done), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(3 * n + 1 + extra));
        check({tag, "_fetches"}, 32'(fetch_i), 32'(n));
        check({tag, "_res_data"}, 32'(res_data), 32'(exp));
        if (n == 0) begin
            check({tag, "_no_rd_req"}, 32'(saw_rd), 32'd0);
            check({tag, "_no_mac_en"}, 32'(saw_mac), 32'd0);
        end
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check($sformatf("%s_hold%0d_valid", tag, h), 32'(res_valid), 32'd1);
            check($sformatf("%s_hold%0d_data", tag, h), 32'(res_data), 32'(exp));
            check($sformatf("%s_hold%0d_cmd_ready", tag, h), 32'(cmd_ready), 32'd0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        check({tag, "_released"}, 32'(res_valid), 32'd0);
        check({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check({tag, "_idle_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int macs;
        logic [ADDR_W-1:0] rb;
        int rn;
        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_chunks = '0;
        cmd_base   = '0;
        res_ready  = 1'b0;
        stall      = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        #1;
        check_reset_outputs("por");
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        fill_const(10'h010, 1, 8'd1, 8'd1);
        check("ones_ref", 32'(ref_result(10'h010, 1)), 32'd33);
        run_cmd("ones", 10'h010, 1, -1, 0, 0, 1'b0);

        fill_const(10'h3FE, 3, 8'd2, 8'd3);
        check("wrap_ref", 32'(ref_result(10'h3FE, 3)), 32'd594);
        run_cmd("wrap", 10'h3FE, 3, -1, 0, 0, 1'b0);

        fill_const(10'h100, 1, 8'h80, 8'd127);
        check("neg_ref", 32'(ref_result(10'h100, 1)), 32'h00F7D080);
        run_cmd("neg", 10'h100, 1, -1, 0, 0, 1'b0);

        fill_const(10'h200, 32, 8'd127, 8'd127);
        check("big_ref", 32'(ref_result(10'h200, 32)), 32'h0003E420);
        run_cmd("big_stall", 10'h200, 32, 5, 2, 0, 1'b0);

        run_cmd("zero", 10'h055, 0, -1, 0, 5, 1'b1);

        // Reset during the MAC cycle of chunk 2 of a 4-chunk command.
        fill_rand(10'h020, 4);
        cmd_valid  = 1'b1;
        cmd_chunks = 8'd4;
        cmd_base   = 10'h020;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        macs = 0;
        for (int c = 0; c < 40 && macs < 2; c++) begin
            if (mac_en) macs++;
            if (macs < 2) begin
                @(posedge clk); #1;
            end
        end
        check("rst_reached_mac2", 32'(macs), 32'd2);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b0;
        fill_rand(10'h0A0, 1);
        run_cmd("after_rst", 10'h0A0, 1, -1, 0, 0, 1'b0);

        for (int t = 0; t < 4; t++) begin
            rb = ADDR_W'($urandom);
            rn = int'($urandom_range(1, 8));
            fill_rand(rb, rn);
            run_cmd($sformatf("rand%0d", t), rb, rn, int'($urandom_range(0, rn - 1)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/int8_mac_seq.md
Name: int8_mac_seq

Overview:
- Sequencer for one int8_mac dot-product engine (33 signed int8 lanes, 24-bit wrapping accumulate).
- Accepts a command naming a chunk count and a base address, and fetches each 264-bit A/B chunk pair from the operand buffer over a req/valid interface.
- Drives the MAC one chunk at a time, carrying the running sum back through the MAC's partial-sum input.
- Returns the final 24-bit sum on a valid/ready result port.
- Sits between the tile scheduler and the MAC datapath.

Parameters:
VEC_W  264  width of one A or B chunk (33 x int8)
ACC_W  24  accumulator/result width (matches MAC)
ADDR_W  10  operand buffer address width
CNT_W  8  chunk count width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when both high
cmd_chunks  in  CNT_W  number of chunks to accumulate
cmd_base  in  ADDR_W  address of first chunk
rd_req  out  1  operand fetch request
rd_addr  out  ADDR_W  fetch address
rd_valid  in  1  rd_a/rd_b valid this cycle
rd_a  in  VEC_W  A chunk
rd_b  in  VEC_W  B chunk
mac_en  out  1  to MAC int8_en
mac_a  out  VEC_W  to MAC a_vec
mac_b  out  VEC_W  to MAC b_vec
mac_psum_in  out  ACC_W  to MAC partial_sum_in
mac_psum_out  in  ACC_W  from MAC partial_sum_out (registered, 1-cycle latency)
res_valid  out  1  result available
res_ready  in  1  result consumed when both high
res_data  out  ACC_W  final sum, two's complement mod 2^ACC_W
busy  out  1  high in any state other than IDLE

Behaviour:

Clock and reset:
- One clock: clk.
- Reset rst is asynchronous and active-high.
- Reset, including mid-operation, forces IDLE and clears all state.
- Reset values: cmd_ready=1 (combinational from IDLE), rd_req=0, rd_addr=0, mac_en=0, mac_a=0, mac_b=0, mac_psum_in=0, res_valid=0, res_data=0, busy=0.
- Internal acc, idx and count registers clear to 0.

States: IDLE, FETCH, MAC, CAPTURE, DONE.

IDLE:
- cmd_ready=1.
- On cmd_valid: latch count=cmd_chunks, addr=cmd_base, idx=0, acc=0.
- If cmd_chunks==0, go to DONE with res_data=0; otherwise go to FETCH.

FETCH:
- rd_req=1, rd_addr=addr.
- Waits indefinitely for rd_valid; rd_valid is ignored outside FETCH.
- On rd_valid: register rd_a/rd_b into mac_a/mac_b, go to MAC.

MAC (exactly 1 cycle):
- mac_en=1, mac_psum_in=acc.
- Go to CAPTURE.

CAPTURE (exactly 1 cycle):
- mac_en=0.
- acc <= mac_psum_out; addr <= addr+1 (wraps mod 2^ADDR_W); idx <= idx+1.
- If idx==count-1, go to DONE with res_data=mac_psum_out; otherwise go to FETCH.

DONE:
- res_valid=1, res_data held stable until res_ready, then go to IDLE.
- cmd_ready=0 here, so no command can overlap a pending result.

Other rules:
- mac_a/mac_b hold their last values when not updated.
- mac_en is high only in MAC; the MAC clears its own output when disabled, so all carry-over lives in acc.
- Arithmetic wraps mod 2^24 with no saturation or overflow flag.
- Latency: with rd_valid returned in the same cycle as rd_req, res_valid rises 3N+1 cycles after the command-accept edge for N≥1; N=0 gives res_valid on the next cycle.
- Each fetch stall cycle adds one cycle.
- Throughput: one command in flight.

Test Plan:
- 1 chunk, all A=1, B=1, zero-wait memory -> res_data=33 (0x000021); res_valid 4 cycles after accept; rd_addr=cmd_base.
- cmd_base=0x3FE, 3 chunks, A=2, B=3 -> res_data=594; rd_addr sequence 0x3FE, 0x3FF, 0x000.
- 1 chunk, A=-128, B=127 -> res_data=0xF7D080 (-536448).
- 32 chunks, A=127, B=127 -> 17032224 mod 2^24 = 0x03E420; also hold rd_valid low for 2 cycles on chunk 5 -> rd_req/rd_addr stay stable and the result is unchanged.
- cmd_chunks=0 -> res_valid next cycle, res_data=0, rd_req and mac_en never asserted. Hold res_ready low for 5 cycles -> res_data stable and cmd_ready=0 while cmd_valid stays high.
- Assert rst during MAC of chunk 2 of 4 -> all outputs reset values immediately. A new 1-chunk command then returns the correct sum with no stale acc.
